// File: rtl/fault_pkg.sv
// Shared types for the fault detection slice: FSM states, fault cause codes,
// and the width of the consecutive-mismatch streak counter.
package fault_pkg;

  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    ST_MONITOR = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_LOCKSTEP = 2'd1,
    FC_PARITY   = 2'd2,
    FC_WDOG     = 2'd3
  } fcode_e;

endpackage

// File: rtl/fault_detect_unit_if.sv
// Commit-compare, error-strobe and clear-handshake bundle of the fault monitor.
// master drives the checked streams and clear_req; slave is the monitor.
interface fault_detect_unit_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);

  logic              chk_valid;
  logic [DATA_W-1:0] pc_a;
  logic [DATA_W-1:0] pc_b;
  logic [DATA_W-1:0] res_a;
  logic [DATA_W-1:0] res_b;
  logic              par_err;
  logic              heartbeat;
  logic              wdog_en;
  logic              clear_req;
  logic              clear_ack;
  logic              fault_detected;
  logic [1:0]        fault_code;
  logic [CNT_W-1:0]  event_count;

  modport master (
    output chk_valid, pc_a, pc_b, res_a, res_b, par_err, heartbeat, wdog_en, clear_req,
    input  clear_ack, fault_detected, fault_code, event_count
  );

  modport slave (
    input  chk_valid, pc_a, pc_b, res_a, res_b, par_err, heartbeat, wdog_en, clear_req,
    output clear_ack, fault_detected, fault_code, event_count
  );

endinterface

// File: rtl/fault_watchdog.sv
// Retire-heartbeat watchdog: counts idle cycles, expire is registered and stays
// high once the count saturates at WDOG_CYCLES-1; freeze holds, clear zeroes.
module fault_watchdog #(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic heartbeat,
  input  logic freeze,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(WDOG_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(WDOG_CYCLES - 1);

  logic [CW-1:0] cnt;

  // heartbeat is checked before the limit so it wins over a same-cycle expiry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else if (clear || !en) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else if (freeze) begin
      expire <= 1'b0;
    end else if (heartbeat) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else begin
      expire <= (cnt == LIMIT);
      if (cnt != LIMIT) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fault_detect_unit.sv
// Lockstep/parity/watchdog fault monitor with sticky fault flag and req/ack clear.
// Every cause registers once, then moves the FSM one edge later (2-edge latency).
module fault_detect_unit
  import fault_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int MISMATCH_THRESH = 3,
  parameter int WDOG_CYCLES     = 1024,
  parameter int CNT_W           = 8
) (
  input logic clk,
  input logic reset_n,
  fault_detect_unit_if.slave bus
);

  localparam logic [1:0] S_MONITOR = ST_MONITOR;
  localparam logic [1:0] S_SUSPECT = ST_SUSPECT;
  localparam logic [1:0] S_FAULT   = ST_FAULT;

  logic [DATA_W-1:0]   pc_diff, res_diff;
  logic                mismatch;
  logic                mm_q, ok_q, par_q, wdog_q;
  logic                req_q, req_d, fire, clr_fault;
  logic [1:0]          state;
  logic [STREAK_W-1:0] streak, streak_inc;
  logic                fault_q, ack_q, enter;
  logic [1:0]          code_q;
  fcode_e              cause;
  logic [CNT_W-1:0]    count_q;

  assign pc_diff    = bus.pc_a ^ bus.pc_b;
  assign res_diff   = bus.res_a ^ bus.res_b;
  assign mismatch   = (|pc_diff) | (|res_diff);
  assign fire       = req_q & ~req_d;
  assign clr_fault  = fire && (state == S_FAULT);
  assign streak_inc = streak + 1'b1;

  fault_watchdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (bus.wdog_en),
    .heartbeat (bus.heartbeat),
    .freeze    (state == S_FAULT),
    .clear     (clr_fault),
    .expire    (wdog_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mm_q  <= 1'b0;
      ok_q  <= 1'b0;
      par_q <= 1'b0;
    end else if (clr_fault) begin
      mm_q  <= 1'b0;
      ok_q  <= 1'b0;
      par_q <= 1'b0;
    end else begin
      mm_q  <= bus.chk_valid & mismatch;
      ok_q  <= bus.chk_valid & ~mismatch;
      par_q <= bus.par_err;
    end
  end

  // clear_req is a level; only its first sampled-high cycle is acknowledged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q <= 1'b0;
      req_d <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      req_q <= bus.clear_req;
      req_d <= req_q;
      ack_q <= fire;
    end
  end

  always_comb begin
    enter = 1'b0;
    cause = FC_NONE;
    if (state != S_FAULT) begin
      if (par_q) begin
        enter = 1'b1;
        cause = FC_PARITY;
      end else if (wdog_q) begin
        enter = 1'b1;
        cause = FC_WDOG;
      end else if (mm_q && (streak_inc == STREAK_W'(MISMATCH_THRESH))) begin
        enter = 1'b1;
        cause = FC_LOCKSTEP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_MONITOR;
      streak  <= '0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      count_q <= '0;
    end else if (clr_fault) begin
      state   <= S_MONITOR;
      streak  <= '0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
    end else if (enter) begin
      state   <= S_FAULT;
      fault_q <= 1'b1;
      code_q  <= cause;
      if (count_q != {CNT_W{1'b1}}) count_q <= count_q + 1'b1;
    end else if (state != S_FAULT) begin
      if (mm_q) begin
        state  <= S_SUSPECT;
        streak <= streak_inc;
      end else if (ok_q) begin
        state  <= S_MONITOR;
        streak <= '0;
      end
    end
  end

  assign bus.clear_ack      = ack_q;
  assign bus.fault_detected = fault_q;
  assign bus.fault_code     = code_q;
  assign bus.event_count    = count_q;

endmodule

// File: doc/fault_detect_unit.md
Name: fault_detect_unit

Overview:
Upstream monitor that produces the core's fault_detected input. It performs lockstep comparison of a primary and a shadow commit stream, qualifies consecutive mismatches against a threshold, and takes a register-file parity error input. It also runs a retire-heartbeat watchdog. Any confirmed fault is latched sticky until software clears it through a req/ack handshake.

Parameters:
DATA_W, 32, width of compared PC and result buses
MISMATCH_THRESH, 3, consecutive valid mismatches that confirm a lockstep fault (legal range 1..15)
WDOG_CYCLES, 1024, cycles without heartbeat before watchdog fault (>=2)
CNT_W, 8, width of saturating lifetime event counter

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
chk_valid  in  1  primary/shadow commit pair valid this cycle
pc_a  in  DATA_W  primary committed PC
pc_b  in  DATA_W  shadow committed PC
res_a  in  DATA_W  primary writeback result
res_b  in  DATA_W  shadow writeback result
par_err  in  1  register-file parity error strobe
heartbeat  in  1  retire pulse from core WB stage
wdog_en  in  1  watchdog enable
clear_req  in  1  level request to clear a latched fault
clear_ack  out  1  one-cycle acknowledge of clear_req
fault_detected  out  1  sticky fault flag to core
fault_code  out  2  cause of first fault: 0 NONE, 1 LOCKSTEP, 2 PARITY, 3 WDOG
event_count  out  CNT_W  saturating count of confirmed faults since reset

Behaviour:
- Reset (async, reset_n low): state MONITOR; fault_detected=0, fault_code=0, clear_ack=0, event_count=0; streak and watchdog counters=0; input pipe registers cleared.
- Stage 1 (registered): mm_q <= chk_valid & ((pc_a!=pc_b)|(res_a!=res_b)); ok_q <= chk_valid & match; par_q <= par_err; wdog_q <= watchdog expiry.
- Stage 2: FSM acts on the stage-1 registers. Every source has 2-edge latency: an input sampled at edge N changes state at edge N+1.
- FSM MONITOR: par_q -> FAULT (PARITY). Else wdog_q -> FAULT (WDOG). Else mm_q -> SUSPECT with streak=1, or directly FAULT (LOCKSTEP) if THRESH=1.
- FSM SUSPECT: par_q/wdog_q as in MONITOR. mm_q -> streak+1; when streak+1==THRESH -> FAULT (LOCKSTEP). ok_q -> MONITOR, streak=0. Cycles with neither flag hold streak.
- FSM FAULT: fault_detected=1. fault_code frozen at the first cause, and later causes are ignored. Watchdog counter is frozen.
- Priority on simultaneous causes: PARITY > WDOG > LOCKSTEP.
- event_count increments by 1 on every entry into FAULT and saturates at all-ones. It is never cleared by clear_req.
- Watchdog: counts cycles while wdog_en=1 and state!=FAULT. A heartbeat resets the count to 0, and heartbeat wins over expiry in the same cycle. Expiry occurs when the count reaches WDOG_CYCLES-1, after which the counter saturates. wdog_en=0 holds the count at 0.
- Clear handshake: clear_ack pulses for exactly one cycle, on the edge after clear_req is first seen high (rising-edge detect). A held-high clear_req does not re-ack.
- Clear in FAULT: returns to MONITOR and zeroes fault_detected, fault_code, streak, the watchdog count and all stage-1 registers. Any fault cause sampled on the same edge is discarded.
- Clear outside FAULT: still acked, with no state change.
- Reset mid-operation: all state is dropped immediately, with no fault reported.
- All outputs are registered.

Decomposition:
- fault_pkg holds the state enum (MONITOR, SUSPECT, FAULT) and the fault_code enum (NONE, LOCKSTEP, PARITY, WDOG), plus a width constant for the streak counter (4 bits).
- One sub-module, fault_watchdog, holds the parameterised counter with heartbeat, enable, freeze and clear inputs and a registered expire output.

Test Plan:
- Lockstep, THRESH=3: valid mismatches (pc_a=0x100, pc_b=0x104) at edges 5,6,7 -> fault_detected=1 and fault_code=1 after edge 8; event_count=1.
- Two mismatches then a matching valid pair, followed by a third mismatch -> FSM returns to MONITOR, fault_detected stays 0, and the streak restarts at 1.
- par_err at edge 10 together with a mismatch -> fault_detected after edge 11 with fault_code=2 (parity wins); a later watchdog expiry leaves the code at 2.
- WDOG_CYCLES=16, wdog_en=1, no heartbeat -> fault_code=3 about 17 edges after enable. A heartbeat at count 14 postpones expiry by 15 further cycles.
- Fault latched, clear_req raised at edge 20 and held for 5 cycles -> one clear_ack pulse after edge 21, state MONITOR, fault_code=0, event_count unchanged; a par_err on edge 21 is discarded.
- reset_n asserted asynchronously mid-SUSPECT -> all outputs 0 at once; event_count saturates at 255 under repeated fault and clear cycles.
